hilo_mdu: RTL and testbench

//  Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
//  - Consumes the two register-file read buses (rs on a, rt on b).
//  - Executes MULT/MULTU/DIV/DIVU over multiple cycles.
//  - Holds results in HI/LO, which MFHI/MFLO forward to the register-file write bus.
//  - Control stalls the pipeline while busy=1.

---
 rtl/hilo_mdu.sv | 155 +++++++++++++++
 tb/tb_hilo_mdu.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit holding HI/LO for the MIPS datapath.
// Shift-add multiply and restoring divide, one bit per cycle, sign-fixed in a final cycle.
module hilo_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFinal = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             is_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign is_signed = ~op_i[0];
    assign a_neg     = is_signed & a_i[WIDTH-1];
    assign b_neg     = is_signed & b_i[WIDTH-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;

    assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
    // acc stays below the divisor, so bit WIDTH of the difference is a clean borrow flag
    assign div_shift = {acc_q, mq_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    assign prod      = {acc_q, mq_q};
    assign prod_fix  = neg_q ? -prod : prod;
    assign quo_fix   = dbz_q ? {WIDTH{1'b1}} : (neg_q ? -mq_q : mq_q);
    assign rem_fix   = rneg_q ? -acc_q : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    div_d   = op_i[1];
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dbz_d   = op_i[1] && (b_i == '0);
                    acc_d   = '0;
                    mq_d    = op_i[1] ? a_mag : b_mag;
                    opb_d   = op_i[1] ? b_mag : a_mag;
                end else begin
                    if (mthi_i) hi_d = a_i;
                    if (mtlo_i) lo_d = a_i;
                end
            end
            StRun: begin
                if (div_q) begin
                    acc_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            acc_q   <= '0;
            mq_q    <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: hand-computed products, quotients and control corner cases.
module tb_hilo_mdu;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    hilo_mdu #(
        .WIDTH(W)
    ) u_dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .mthi_i  (mthi),
        .mtlo_i  (mtlo),
        .hi_o    (hi),
        .lo_o    (lo),
        .busy_o  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a start (with optional mt strobes) for the next rising edge.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic hi_wr, input logic lo_wr);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        mthi  = hi_wr;
        mtlo  = lo_wr;
    endtask

    // Count busy cycles, optionally inject ignored strobes at cycle 10, then check results.
    task automatic finish_op(input string tag, input bit inj, input bit chk_hold,
                             input logic [W-1:0] hold_hi, input logic [W-1:0] exp_hi,
                             input logic [W-1:0] exp_lo);
        int n = 0;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        if (chk_hold) check_eq({tag, " hi held"}, 64'(hi), 64'(hold_hi));
        while (busy && n < 100) begin
            if (inj && n == 10) begin
                start = 1'b1;
                op    = 2'b10;
                a     = 32'h1234;
                mthi  = 1'b1;
            end else begin
                start = 1'b0;
                mthi  = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        mthi  = 1'b0;
        check_eq({tag, " busy cycles"}, 64'(n), 64'd33);
        check_eq({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check_eq({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset hi", 64'(hi), 64'd0);
        check_eq("reset lo", 64'(lo), 64'd0);
        check_eq("reset busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        launch(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        finish_op("MULT -3*7", 1'b0, 1'b0, '0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        finish_op("MULTU max*max", 1'b0, 1'b0, '0, 32'hFFFF_FFFE, 32'h0000_0001);

        launch(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        finish_op("MULT min*min", 1'b0, 1'b0, '0, 32'h4000_0000, 32'h0000_0000);

        launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        finish_op("DIV -7/2", 1'b0, 1'b0, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        launch(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        finish_op("DIV 7/-2", 1'b0, 1'b0, '0, 32'h0000_0001, 32'hFFFF_FFFD);

        launch(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        finish_op("DIVU 100/7", 1'b0, 1'b0, '0, 32'd2, 32'd14);

        launch(2'b11, 32'h64, 32'd0, 1'b0, 1'b0);
        finish_op("DIVU by 0", 1'b0, 1'b0, '0, 32'h64, 32'hFFFF_FFFF);

        launch(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
        finish_op("DIV -7 by 0", 1'b0, 1'b0, '0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        finish_op("DIV min/-1", 1'b0, 1'b0, '0, 32'h0000_0000, 32'h8000_0000);

        launch(2'b00, 32'd5, 32'd6, 1'b0, 1'b0);
        finish_op("MULT 5*6 ignored strobes", 1'b1, 1'b0, '0, 32'd0, 32'd30);

        // mthi and mtlo together write both registers
        @(negedge clk);
        a    = 32'h5555;
        mthi = 1'b1;
        mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check_eq("mthi+mtlo hi", 64'(hi), 64'h5555);
        check_eq("mthi+mtlo lo", 64'(lo), 64'h5555);

        // start beats a simultaneous mthi
        launch(2'b01, 32'd2, 32'd3, 1'b1, 1'b0);
        finish_op("MULTU 2*3 start+mthi", 1'b0, 1'b1, 32'h5555, 32'd0, 32'd6);

        @(negedge clk);
        a    = 32'hCAFE;
        mtlo = 1'b1;
        @(negedge clk);
        mtlo = 1'b0;
        check_eq("mtlo lo", 64'(lo), 64'hCAFE);
        check_eq("mtlo hi kept", 64'(hi), 64'd0);

        // asynchronous reset mid-operation
        launch(2'b00, 32'd5, 32'd6, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("busy before reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid-op reset hi", 64'(hi), 64'd0);
        check_eq("mid-op reset lo", 64'(lo), 64'd0);
        check_eq("mid-op reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(2'b11, 32'd9, 32'd4, 1'b0, 1'b0);
        finish_op("DIVU 9/4 after reset", 1'b0, 1'b0, '0, 32'd1, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
